// File: rtl/cam_pixel_packer.sv
// cam_pixel_packer
//   Camera-domain capture front end. Turns the OV7670 byte stream (VSYNC/HREF/D)
//   into 17-bit FIFO words: 17'h10000 marks a frame start; otherwise bits[15:0]
//   carry one RGB565 pixel (high byte first on the wire).
//
// Ports
//   clk          camera pixel clock, all inputs sampled on posedge
//   rst_n        synchronous active-low reset
//   cam_vsync    camera VSYNC (polarity set by VSYNC_ACTIVE_HIGH)
//   cam_href     camera HREF, high = valid byte on cam_data
//   cam_data     camera byte
//   fifo_full    FIFO Full flag; no word is ever written while it is high
//   fifo_data    word to FIFO Data
//   fifo_wr_en   FIFO WrEn, one-cycle pulse per word
//   frame_active high while a frame is being forwarded
//   overflow     sticky, a frame was dropped because of fifo_full
//   geom_error   one-cycle pulse on a wrong-sized line or frame
//   frame_count  frames fully forwarded, wraps
module cam_pixel_packer #(
    parameter int unsigned FRAME_WIDTH       = 640,
    parameter int unsigned FRAME_HEIGHT      = 480,
    parameter bit          VSYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_full,
    output logic [16:0] fifo_data,
    output logic        fifo_wr_en,
    output logic        frame_active,
    output logic        overflow,
    output logic        geom_error,
    output logic [15:0] frame_count
);

    localparam logic [1:0] StWaitVsync = 2'd0;
    localparam logic [1:0] StActive    = 2'd1;
    localparam logic [1:0] StDrop      = 2'd2;

    localparam logic [16:0] Marker    = 17'h10000;
    localparam logic [10:0] WidthCnt  = 11'(FRAME_WIDTH);
    localparam logic [10:0] HeightCnt = 11'(FRAME_HEIGHT);

    // Input capture stage; this register is what gives the N -> N+1 output latency.
    logic       vs_q, vs_prev_q, href_q, href_prev_q;
    logic [7:0] data_q;

    logic [1:0]  state_q, state_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [10:0] pix_q, pix_d;
    logic [10:0] line_q, line_d;
    logic [16:0] fifo_data_q, fifo_data_d;
    logic        wr_en_q, wr_en_d;
    logic        overflow_q, overflow_d;
    logic        geom_q, geom_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic vs_now;
    logic frame_start;
    logic vs_assert;

    assign vs_now      = VSYNC_ACTIVE_HIGH ? cam_vsync : ~cam_vsync;
    assign frame_start = vs_prev_q & ~vs_q;
    assign vs_assert   = ~vs_prev_q & vs_q;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        pix_d         = pix_q;
        line_d        = line_q;
        fifo_data_d   = fifo_data_q;
        wr_en_d       = 1'b0;
        overflow_d    = overflow_q;
        geom_d        = 1'b0;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StWaitVsync: begin
                if (frame_start) begin
                    phase_d = 1'b0;
                    pix_d   = '0;
                    line_d  = '0;
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                        state_d    = StDrop;
                    end else begin
                        wr_en_d     = 1'b1;
                        fifo_data_d = Marker;
                        state_d     = StActive;
                    end
                end
            end
            StActive: begin
                // vsync beats a coincident href byte; that byte is discarded.
                if (vs_assert) begin
                    if (line_q != HeightCnt) begin
                        geom_d = 1'b1;
                    end
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = StWaitVsync;
                end else if (href_q) begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (fifo_full) begin
                            overflow_d = 1'b1;
                            state_d    = StDrop;
                        end else begin
                            wr_en_d     = 1'b1;
                            fifo_data_d = {1'b0, hi_q, data_q};
                            if (pix_q != '1) begin
                                pix_d = pix_q + 11'd1;
                            end
                        end
                    end
                end else if (href_prev_q) begin
                    // Line end: odd byte count and wrong width share one pulse.
                    if (phase_q || (pix_q != WidthCnt)) begin
                        geom_d = 1'b1;
                    end
                    phase_d = 1'b0;
                    pix_d   = '0;
                    if (line_q != '1) begin
                        line_d = line_q + 11'd1;
                    end
                end
            end
            StDrop: begin
                if (vs_assert) begin
                    state_d = StWaitVsync;
                end
            end
            default: state_d = StWaitVsync;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            vs_prev_q     <= 1'b0;
            href_q        <= 1'b0;
            href_prev_q   <= 1'b0;
            data_q        <= 8'd0;
            state_q       <= StWaitVsync;
            phase_q       <= 1'b0;
            hi_q          <= 8'd0;
            pix_q         <= '0;
            line_q        <= '0;
            fifo_data_q   <= '0;
            wr_en_q       <= 1'b0;
            overflow_q    <= 1'b0;
            geom_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            vs_q          <= vs_now;
            vs_prev_q     <= vs_q;
            href_q        <= cam_href;
            href_prev_q   <= href_q;
            data_q        <= cam_data;
            state_q       <= state_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            pix_q         <= pix_d;
            line_q        <= line_d;
            fifo_data_q   <= fifo_data_d;
            wr_en_q       <= wr_en_d;
            overflow_q    <= overflow_d;
            geom_q        <= geom_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign fifo_data    = fifo_data_q;
    assign fifo_wr_en   = wr_en_q;
    assign frame_active = (state_q == StActive);
    assign overflow     = overflow_q;
    assign geom_error   = geom_q;
    assign frame_count  = frame_count_q;

endmodule
